// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
// Addresses, funct3 operation codes, status/interrupt bit positions, masks.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // funct3[1:0] selects the operation, funct3[2] selects the immediate
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam int F3_IMM_BIT = 2;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;
  localparam int MTVEC_RSVD_BIT = 1;

  function automatic logic csr_known(input logic [11:0] addr);
    logic hit;
    hit = 1'b0;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
      CSR_MHARTID: hit = 1'b1;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/csr_file_m_counter.sv
// csr_counter: free-running counter with increment enable.
// Low/high 32-bit halves are separately writable; a write drops the increment.
module csr_counter
  #(parameter int CNT_WIDTH = 64)
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] lo,
    output logic [31:0] hi
  );

  logic [CNT_WIDTH-1:0] cnt;
  logic [63:0]          cur;
  logic [63:0]          nxt;

  assign cur = 64'(cnt);
  assign lo  = cur[31:0];
  assign hi  = cur[63:32];

  // next value: half replacement wins over the increment
  always_comb begin
    nxt = cur;
    if (wr_lo) nxt[31:0] = wdata;
    if (wr_hi) nxt[63:32] = wdata;
    if (!wr_lo && !wr_hi && inc) nxt = cur + 64'd1;
  end

  // counter register, wraps by truncation to CNT_WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt[CNT_WIDTH-1:0];
  end

endmodule

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with trap sequencing,
// interrupt pending logic, cycle/instret counters and access checking.
module csr_file_m
  import csr_pkg::*;
  #(
    parameter int              XLEN        = 32,
    parameter int              CNT_WIDTH   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
  )
  (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic            csr_write_enable,
    input  logic [2:0]      csr_funct3,
    input  logic            csr_src_zero,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      csr_imm,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_pending
  );

  logic            st_mie;
  logic            st_mpie;
  logic [XLEN-1:0] mie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
  logic [XLEN-1:0] mtval_r;
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] mtvec_rd;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] base;
  logic [31:0]     cyc_lo;
  logic [31:0]     cyc_hi;
  logic [31:0]     ins_lo;
  logic [31:0]     ins_hi;
  csr_op_e         op;
  logic            known;
  logic            ro;
  logic            writes;
  logic            wr_en;

  assign op     = csr_op_e'(csr_funct3[1:0]);
  assign src    = csr_funct3[F3_IMM_BIT] ? XLEN'(csr_imm) : rs1_data;
  assign known  = csr_known(csr_addr);
  assign ro     = (csr_addr[11:10] == 2'b11);
  assign writes = csr_write_enable && (op != OP_NONE)
                  && ((op == OP_RW) || !csr_src_zero);

  // a trap swallows the CSR instruction, so nothing is flagged
  assign csr_illegal = !trap_valid && csr_write_enable
                       && (!known || (op == OP_NONE) || (ro && writes));
  assign wr_en = writes && !csr_illegal && !trap_valid;

  assign mtvec_rd = mtvec_r & ~(XLEN'(1) << MTVEC_RSVD_BIT);
  assign mepc_out = mepc_r;

  // live interrupt lines as seen through mip
  always_comb begin
    mip_val           = '0;
    mip_val[MIP_MEIP] = irq_ext;
    mip_val[MIP_MTIP] = irq_timer;
  end

  // read mux: pre-write value of the addressed CSR
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MPP+:2]  = 2'b11;
        csr_rdata[MSTATUS_MPIE]    = st_mpie;
        csr_rdata[MSTATUS_MIE]     = st_mie;
      end
      CSR_MIE:                    csr_rdata = mie_r;
      CSR_MTVEC:                  csr_rdata = mtvec_rd;
      CSR_MSCRATCH:               csr_rdata = mscratch_r;
      CSR_MEPC:                   csr_rdata = mepc_r;
      CSR_MCAUSE:                 csr_rdata = mcause_r;
      CSR_MTVAL:                  csr_rdata = mtval_r;
      CSR_MIP:                    csr_rdata = mip_val;
      CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = XLEN'(cyc_lo);
      CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = XLEN'(cyc_hi);
      CSR_MINSTRET, CSR_INSTRET:  csr_rdata = XLEN'(ins_lo);
      CSR_MINSTRETH,CSR_INSTRETH: csr_rdata = XLEN'(ins_hi);
      CSR_MHARTID:                csr_rdata = HART_ID;
      default:                    csr_rdata = '0;
    endcase
  end

  // read-modify-write value for the selected operation
  always_comb begin
    case (op)
      OP_RS:   wdata = csr_rdata | src;
      OP_RC:   wdata = csr_rdata & ~src;
      default: wdata = src;
    endcase
  end

  // trap target: direct, or vectored for interrupts
  always_comb begin
    base        = {mtvec_rd[XLEN-1:2], 2'b00};
    trap_vector = base;
    if (mtvec_rd[0] && trap_cause[XLEN-1])
      trap_vector = base + {trap_cause[XLEN-3:0], 2'b00};
  end

  assign irq_pending = st_mie && |(mie_r & mip_val);

  // architectural state: trap entry, then mret, then CSR writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_r      <= '0;
      mtvec_r    <= MTVEC_RESET;
      mscratch_r <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
      mtval_r    <= '0;
    end else if (trap_valid) begin
      mepc_r   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause_r <= trap_cause;
      mtval_r  <= trap_tval;
      st_mpie  <= st_mie;
      st_mie   <= 1'b0;
    end else begin
      if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr_en && csr_addr == CSR_MSTATUS) begin
        st_mie  <= wdata[MSTATUS_MIE];
        st_mpie <= wdata[MSTATUS_MPIE];
      end
      if (wr_en) begin
        case (csr_addr)
          CSR_MIE:      mie_r      <= wdata & XLEN'(MIE_WMASK);
          CSR_MTVEC:    mtvec_r    <= wdata & ~(XLEN'(1) << MTVEC_RSVD_BIT);
          CSR_MSCRATCH: mscratch_r <= wdata;
          CSR_MEPC:     mepc_r     <= {wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_r   <= wdata;
          CSR_MTVAL:    mtval_r    <= wdata;
          default:      ;
        endcase
      end
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (wr_en && csr_addr == CSR_MCYCLE),
    .wr_hi (wr_en && csr_addr == CSR_MCYCLEH),
    .wdata (wdata[31:0]),
    .lo    (cyc_lo),
    .hi    (cyc_hi)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instr_retire),
    .wr_lo (wr_en && csr_addr == CSR_MINSTRET),
    .wr_hi (wr_en && csr_addr == CSR_MINSTRETH),
    .wdata (wdata[31:0]),
    .lo    (ins_lo),
    .hi    (ins_hi)
  );

endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed test-plan sequence followed by random traffic,
// all checked against a behavioural CSR model.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic        we = 1'b0;
  logic [2:0]  f3 = '0;
  logic        sz = 1'b0;
  logic [31:0] rs1 = '0;
  logic [4:0]  imm = '0;
  logic        retire = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] cause = '0;
  logic [31:0] pc = '0;
  logic [31:0] tval = '0;
  logic        mret = 1'b0;
  logic        iext = 1'b0;
  logic        itim = 1'b0;

  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_pending;

  localparam logic [31:0] RST_VEC = 32'h0000_0100;
  localparam logic [31:0] HART    = 32'd5;

  csr_file_m #(
    .XLEN(32), .CNT_WIDTH(64),
    .MTVEC_RESET(RST_VEC), .HART_ID(HART)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_addr(addr), .csr_write_enable(we),
    .csr_funct3(f3), .csr_src_zero(sz),
    .rs1_data(rs1), .csr_imm(imm),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retire(retire), .trap_valid(trap),
    .trap_cause(cause), .trap_pc(pc), .trap_tval(tval),
    .mret(mret), .irq_ext(iext), .irq_timer(itim),
    .trap_vector(trap_vector), .mepc_out(mepc_out),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch;
  logic [31:0] m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  logic [31:0] obs_rdata, obs_vec, obs_mepc;
  logic        obs_ill, obs_irq;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_mip();
    return (32'(iext) << 11) | (32'(itim) << 7);
  endfunction

  function automatic bit m_known(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
      12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
      12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec & ~32'h2;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_mstatus  = 32'h0000_1800;
    m_mie      = '0;
    m_mtvec    = RST_VEC;
    m_mscratch = '0;
    m_mepc     = '0;
    m_mcause   = '0;
    m_mtval    = '0;
    m_cyc      = '0;
    m_ins      = '0;
  endtask

  // one clock: check combinational outputs, then advance the model
  task automatic step();
    logic [31:0] old, src, nv, ev;
    bit wr, ill, irq, doit, was_mie, was_mpie;
    #1;
    old = m_read(addr);
    src = f3[2] ? {27'b0, imm} : rs1;
    wr  = we && (f3[1:0] != 2'b00) && (f3[1:0] == 2'b01 || !sz);
    ill = !trap && we && (!m_known(addr) || f3[1:0] == 2'b00
                          || (addr[11:10] == 2'b11 && wr));
    ev  = m_mtvec & ~32'h3;
    if (m_mtvec[0] && cause[31]) ev = ev + (cause & 32'h7FFF_FFFF) * 4;
    irq = m_mstatus[3] && ((m_mie & m_mip()) != 0);
    obs_rdata = csr_rdata;
    obs_ill   = csr_illegal;
    obs_vec   = trap_vector;
    obs_irq   = irq_pending;
    obs_mepc  = mepc_out;
    chk("rdata", obs_rdata, old);
    chk("illegal", obs_ill, ill);
    chk("vector", obs_vec, ev);
    chk("irq", obs_irq, irq);
    chk("mepc", obs_mepc, m_mepc);
    case (f3[1:0])
      2'b10:   nv = old | src;
      2'b11:   nv = old & ~src;
      default: nv = src;
    endcase
    doit = wr && !ill && !trap;
    @(posedge clk);
    if (doit && addr == 12'hB00)      m_cyc[31:0]  = nv;
    else if (doit && addr == 12'hB80) m_cyc[63:32] = nv;
    else                              m_cyc        = m_cyc + 1;
    if (doit && addr == 12'hB02)      m_ins[31:0]  = nv;
    else if (doit && addr == 12'hB82) m_ins[63:32] = nv;
    else if (retire)                  m_ins        = m_ins + 1;
    was_mie  = m_mstatus[3];
    was_mpie = m_mstatus[7];
    if (trap) begin
      m_mepc    = pc & ~32'h3;
      m_mcause  = cause;
      m_mtval   = tval;
      m_mstatus = 32'h1800 | (was_mie ? 32'h80 : 32'h0);
    end else begin
      if (mret)
        m_mstatus = 32'h1888 & ~(was_mpie ? 32'h0 : 32'h8);
      else if (doit && addr == 12'h300)
        m_mstatus = 32'h1800 | (nv & 32'h88);
      if (doit) begin
        case (addr)
          12'h304: m_mie      = nv & 32'h888;
          12'h305: m_mtvec    = nv & ~32'h2;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv;
          12'h343: m_mtval    = nv;
          default: ;
        endcase
      end
    end
    @(negedge clk);
  endtask

  task automatic op(input logic [11:0] a, input logic [2:0] f,
                    input logic [31:0] v, input bit z);
    we = 1'b1; addr = a; f3 = f; rs1 = v; imm = v[4:0]; sz = z;
    trap = 1'b0; mret = 1'b0;
    step();
  endtask

  task automatic rd(input logic [11:0] a);
    op(a, 3'b010, 32'h0, 1'b1);
  endtask

  task automatic ev_only(input bit t, input bit m);
    we = 1'b0; trap = t; mret = m;
    step();
    trap = 1'b0; mret = 1'b0;
  endtask

  logic [11:0] tbl [17] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
    12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
    12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};

  initial begin
    logic [31:0] c0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    rd(12'h300); chk("rst_mstatus", obs_rdata, 32'h0000_1800);
    rd(12'h305); chk("rst_mtvec", obs_rdata, RST_VEC);
    rd(12'hF14); chk("hartid", obs_rdata, HART);
    rd(12'hB00); c0 = obs_rdata;
    rd(12'hB00); chk("cyc_inc", obs_rdata - c0, 32'd1);

    op(12'h304, 3'b001, 32'hFFFF_FFFF, 1'b0);
    chk("mie_old", obs_rdata, 32'h0);
    rd(12'h304); chk("mie_mask", obs_rdata, 32'h0000_0888);
    op(12'h300, 3'b110, 32'h8, 1'b0);
    rd(12'h300); chk("mstatus_si", obs_rdata, 32'h0000_1808);

    op(12'hC00, 3'b001, 32'h1234, 1'b0);
    chk("ro_write_ill", obs_ill, 1'b1);
    rd(12'hC00); chk("ro_read_ok", obs_ill, 1'b0);
    op(12'h340, 3'b000, 32'h1, 1'b0);
    chk("f3_000_ill", obs_ill, 1'b1);
    op(12'h123, 3'b010, 32'h0, 1'b1);
    chk("unknown_ill", obs_ill, 1'b1);

    op(12'h305, 3'b001, 32'h8000_0001, 1'b0);
    itim = 1'b1;
    rd(12'h344); chk("irq_pend", obs_irq, 1'b1);
    we = 1'b0; cause = 32'h8000_0007; pc = 32'h1236; tval = 32'h77;
    ev_only(1'b1, 1'b0);
    chk("trap_vec", obs_vec, 32'h8000_001C);
    itim = 1'b0;
    rd(12'h341); chk("mepc", obs_mepc, 32'h1234);
    rd(12'h300); chk("trap_mstatus", obs_rdata, 32'h0000_1880);
    ev_only(1'b0, 1'b1);
    rd(12'h300); chk("mret_mstatus", obs_rdata, 32'h0000_1888);

    op(12'h340, 3'b001, 32'h55, 1'b0);
    we = 1'b1; addr = 12'h340; f3 = 3'b001; rs1 = 32'hAA; sz = 1'b0;
    trap = 1'b1; cause = 32'h2; pc = 32'h40;
    step();
    trap = 1'b0;
    chk("trap_no_ill", obs_ill, 1'b0);
    rd(12'h340); chk("scratch_kept", obs_rdata, 32'h55);
    ev_only(1'b0, 1'b1);
    ev_only(1'b1, 1'b1);
    rd(12'h300); chk("trap_beats_mret", obs_rdata, 32'h0000_1880);

    op(12'hB00, 3'b001, 32'hFFFF_FFFF, 1'b0);
    op(12'hB80, 3'b001, 32'h0, 1'b0);
    rd(12'hB00); chk("cyc_lo_set", obs_rdata, 32'hFFFF_FFFF);
    rd(12'hB00); chk("cyc_lo_wrap", obs_rdata, 32'h0);
    rd(12'hB80); chk("cyc_hi_carry", obs_rdata, 32'h1);

    for (int i = 0; i < 400; i++) begin
      we     = ($urandom % 4) != 0;
      addr   = ($urandom % 8 == 0) ? 12'($urandom) : tbl[$urandom % 17];
      f3     = 3'($urandom);
      sz     = ($urandom % 4) == 0;
      rs1    = sz ? 32'h0 : $urandom;
      imm    = sz ? 5'h0 : 5'($urandom);
      trap   = ($urandom % 10) == 0;
      cause  = {1'($urandom), 27'h0, 4'($urandom)};
      pc     = $urandom;
      tval   = $urandom;
      mret   = ($urandom % 10) == 0;
      retire = 1'($urandom);
      iext   = 1'($urandom);
      itim   = 1'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Machine-mode CSR file for the single-cycle core; successor to the three-register CSR block.
- Parametrised in data width and counter width.
- Adds trap entry/exit sequencing, interrupt pending logic, 64-bit cycle/instret counters, write masking and illegal-access detection.
- Sits beside the register file. Decode supplies the CSR instruction fields; the exception/branch unit drives trap/mret and consumes trap_vector and mepc_out.

Parameters:
XLEN, 32, data width of CSRs and buses (32 only for counter split; 64 allowed for non-counter regs)
CNT_WIDTH, 64, width of mcycle/minstret (<= 64; upper word read as zero-extended)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 0, value returned by mhartid

Ports:
clk  in  1  clock
rst  in  1  reset
csr_addr  in  12  CSR address
csr_write_enable  in  1  CSR instruction valid this cycle
csr_funct3  in  3  instruction funct3
csr_src_zero  in  1  rs1 field (or uimm) is zero
rs1_data  in  XLEN  register operand
csr_imm  in  5  uimm operand
csr_rdata  out  XLEN  old CSR value (combinational)
csr_illegal  out  1  illegal access this cycle (combinational)
instr_retire  in  1  instruction retires this cycle
trap_valid  in  1  take trap this cycle
trap_cause  in  XLEN  cause; bit XLEN-1 = interrupt
trap_pc  in  XLEN  faulting/interrupted PC
trap_tval  in  XLEN  trap value
mret  in  1  MRET executes this cycle
irq_ext  in  1  external interrupt level
irq_timer  in  1  timer interrupt level
trap_vector  out  XLEN  target PC for trap (combinational)
mepc_out  out  XLEN  current mepc
irq_pending  out  1  enabled interrupt pending (combinational)

Behaviour:
- Implemented CSRs:
  - mstatus 300: writable MIE[3], MPIE[7]; MPP[12:11] reads 2'b11.
  - mie 304: writable bits 11, 7, 3.
  - mtvec 305: bit 1 reads 0.
  - mscratch 340, mepc 341 (bits 1:0 read 0), mcause 342, mtval 343: fully writable.
  - mip 344: bit 11 = irq_ext, bit 7 = irq_timer; read-only content, writes ignored, not illegal.
  - mcycle B00/B80 (low/high), minstret B02/B82.
  - Read-only: cycle C00/C80, instret C02/C82, mhartid F14.
  - Any other address: reads 0, csr_illegal = csr_write_enable.
- funct3 decode:
  - 001 RW, 010 RS, 011 RC use rs1_data.
  - 101/110/111 are the same operations using zero-extended csr_imm.
  - 000/100: csr_illegal, no write.
- Write suppression: RS/RC (and immediate forms) with csr_src_zero = 1 perform no write. RW always writes.
- Write to read-only address (addr[11:10] == 2'b11) with an actual write: csr_illegal = 1, no state change. Read-only access via RS/RC with zero source is legal.
- csr_rdata always shows the pre-write value; the new value is visible the next cycle.
- All state updates on posedge clk. Reset is asynchronous: mstatus = 32'h0000_1800, mie = mepc = mcause = mtval = mscratch = 0, mtvec = MTVEC_RESET, counters = 0.
- Counters:
  - mcycle +1 every cycle; minstret +1 when instr_retire.
  - Both wrap modulo 2^CNT_WIDTH; carry from low to high word within the same cycle.
  - A CSR write to either half replaces that half; the increment is dropped that cycle for that counter.
- Trap entry (trap_valid = 1):
  - mepc <= trap_pc with bits 1:0 cleared; mcause <= trap_cause; mtval <= trap_tval.
  - MPIE <= MIE, MIE <= 0.
  - A CSR write in the same cycle is discarded and csr_illegal is not raised. Counters still update.
- mret (no trap): MIE <= MPIE, MPIE <= 1.
- trap_valid and mret together: trap wins, mret ignored.
- trap_vector:
  - mtvec[1:0] == 00: {mtvec[XLEN-1:2], 2'b00}.
  - mtvec[1:0] == 01 and trap_cause interrupt bit set: base + 4*trap_cause[XLEN-2:0]; otherwise base.
  - Mode 1x is written as 0x (bit 1 forced to 0).
- irq_pending = MIE & |(mie & mip). Purely combinational; irq inputs are assumed already synchronised.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants.
  - funct3 codes.
  - mstatus/mie/mip bit positions.
  - Write-mask constants.
- One sub-module: csr_counter (CNT_WIDTH counter with increment enable and separate low/high write ports), instantiated twice.

Test Plan:
- Reset -> read 300 = 0x00001800, 305 = MTVEC_RESET, F14 = HART_ID, B00 increments by 1 each following cycle.
- CSRRW 304 with 0xFFFFFFFF -> csr_rdata 0, next read 0x00000888; CSRRSI 300 imm 8 -> next read 0x00001808.
- CSRRW C00 -> csr_illegal = 1, no change; CSRRS C00 with csr_src_zero -> illegal 0, returns cycle count; funct3 000 -> illegal.
- mtvec = 0x80000001, MIE = 1, mie[7] = 1, irq_timer = 1 -> irq_pending = 1; trap cause 0x80000007, pc 0x1236 -> trap_vector 0x8000001C, mepc = 0x1234, MIE = 0, MPIE = 1; mret -> MIE = 1.
- trap_valid with CSRRW 340 in the same cycle -> mscratch unchanged; trap + mret together -> MIE stays 0.
- Write B00 = 0xFFFFFFFF, B80 = 0 -> two cycles later B80 = 1, B00 = 0x00000000 (wrap/carry).
